// File: rtl/bin_to_bcd_sequencer.sv
// Binary to packed BCD converter built on a sequential divide-by-10 datapath.
// Each digit costs one cycle plus one cycle per subtraction of ten.
module bin_to_bcd_sequencer #(
  parameter int WIDTH  = 16,
  parameter int DIGITS = 5
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [WIDTH-1:0]      din,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   bcd
);

  localparam int KW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SUB  = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e                 state_q, state_d;
  logic [WIDTH-1:0]       w_q, w_d;
  logic [WIDTH-1:0]       q_q, q_d;
  logic [KW-1:0]          k_q, k_d;
  logic [DIGITS-1:0][3:0] dig_q, dig_d;
  logic [4*DIGITS-1:0]    bcd_q, bcd_d;
  logic                   ge10;
  logic                   last;

  assign ge10 = (w_q >= WIDTH'(10));
  assign last = (k_q == KW'(DIGITS - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      w_q     <= '0;
      q_q     <= '0;
      k_q     <= '0;
      dig_q   <= '0;
      bcd_q   <= '0;
    end else begin
      state_q <= state_d;
      w_q     <= w_d;
      q_q     <= q_d;
      k_q     <= k_d;
      dig_q   <= dig_d;
      bcd_q   <= bcd_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start) state_d = SUB;
      SUB:     if (!ge10 && last) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    w_d   = w_q;
    q_d   = q_q;
    k_d   = k_q;
    dig_d = dig_q;
    bcd_d = bcd_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          w_d = din;
          q_d = '0;
          k_d = '0;
        end
      end
      SUB: begin
        if (ge10) begin
          w_d = w_q - WIDTH'(10);
          q_d = q_q + WIDTH'(1);
        end else begin
          dig_d[k_q] = w_q[3:0];
          w_d        = q_q;
          q_d        = '0;
          // the final digit lands in bcd on the same edge that enters DONE
          if (last) bcd_d = dig_d;
          else      k_d   = k_q + KW'(1);
        end
      end
      default: ;
    endcase
  end

  always_comb begin
    busy = (state_q == SUB);
    done = (state_q == DONE);
  end

  assign bcd = bcd_q;

endmodule

// File: tb/tb_bin_to_bcd_sequencer.sv
// Directed bench for bin_to_bcd_sequencer: latency, result, handshake
// and asynchronous reset behaviour with hand-computed expectations.
module tb_bin_to_bcd_sequencer;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [15:0] din;
  logic        busy;
  logic        done;
  logic [19:0] bcd;

  int vectors = 0;
  int errs    = 0;

  bin_to_bcd_sequencer #(.WIDTH(16), .DIGITS(5)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .din   (din),
    .busy  (busy),
    .done  (done),
    .bcd   (bcd)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Wait for done after an accept; returns SUB-cycle count and busy sanity
  task automatic wait_done(output int n, output bit busy_ok,
                           input logic [19:0] hold_bcd, output bit hold_ok);
    n       = 0;
    busy_ok = 1'b1;
    hold_ok = 1'b1;
    while (!done && n < 8000) begin
      @(posedge clk); #1;
      n++;
      if (!done && !busy) busy_ok = 1'b0;
      if (!done && bcd !== hold_bcd) hold_ok = 1'b0;
    end
  endtask

  task automatic conv(input logic [15:0] d, input logic [19:0] eb,
                      input int en, input string tag);
    int n;
    bit bok;
    bit hok;
    logic [19:0] prev;
    @(negedge clk);
    din   = d;
    start = 1'b1;
    prev  = bcd;
    @(posedge clk); #1;
    start = 1'b0;
    chk({tag, "_busy_after_accept"}, {31'd0, busy}, 32'd1);
    wait_done(n, bok, prev, hok);
    chk({tag, "_latency"}, n, en);
    chk({tag, "_bcd"}, {12'd0, bcd}, {12'd0, eb});
    chk({tag, "_busy_in_done"}, {31'd0, busy}, 32'd0);
    chk({tag, "_busy_stayed_high"}, {31'd0, bok}, 32'd1);
    chk({tag, "_bcd_held"}, {31'd0, hok}, 32'd1);
    @(posedge clk); #1;
    chk({tag, "_done_width"}, {31'd0, done}, 32'd0);
  endtask

  initial begin
    int n;
    bit bok;
    bit hok;

    rst_n = 1'b0;
    start = 1'b1;
    din   = 16'd1234;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_busy", {31'd0, busy}, 32'd0);
    chk("reset_done", {31'd0, done}, 32'd0);
    chk("reset_bcd", {12'd0, bcd}, 32'd0);

    @(negedge clk);
    start = 1'b0;
    rst_n = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    chk("idle_busy", {31'd0, busy}, 32'd0);
    chk("idle_done", {31'd0, done}, 32'd0);
    chk("idle_bcd", {12'd0, bcd}, 32'd0);

    conv(16'd0, 20'h00000, 5, "din0");
    conv(16'd12345, 20'h12345, 1375, "din12345");
    conv(16'd10, 20'h00010, 6, "din10");
    conv(16'd9, 20'h00009, 5, "din9");

    // start held high across two conversions
    @(negedge clk);
    din   = 16'd65535;
    start = 1'b1;
    @(posedge clk); #1;
    chk("b2b_accept1", {31'd0, busy}, 32'd1);
    wait_done(n, bok, 20'h00009, hok);
    chk("b2b_latency1", n, 7284);
    chk("b2b_bcd1", {12'd0, bcd}, 32'h65535);
    chk("b2b_busy1", {31'd0, bok}, 32'd1);
    @(posedge clk); #1;
    chk("b2b_idle_busy", {31'd0, busy}, 32'd0);
    chk("b2b_idle_done", {31'd0, done}, 32'd0);
    din = 16'd12345;
    @(posedge clk); #1;
    chk("b2b_reaccept", {31'd0, busy}, 32'd1);
    start = 1'b0;
    wait_done(n, bok, 20'h65535, hok);
    chk("b2b_latency2", n, 1375);
    chk("b2b_bcd_held", {31'd0, hok}, 32'd1);
    chk("b2b_bcd2", {12'd0, bcd}, 32'h12345);
    @(posedge clk); #1;
    chk("b2b_done_width", {31'd0, done}, 32'd0);

    // reset truly mid-conversion
    @(negedge clk);
    din   = 16'd500;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (30) @(posedge clk);
    #1;
    chk("mid_busy_before", {31'd0, busy}, 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_busy", {31'd0, busy}, 32'd0);
    chk("mid_rst_bcd", {12'd0, bcd}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    conv(16'd500, 20'h00500, 60, "din500");

    // reset 100 cycles after accepting 500
    @(negedge clk);
    din   = 16'd500;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (100) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst100_busy", {31'd0, busy}, 32'd0);
    chk("rst100_done", {31'd0, done}, 32'd0);
    chk("rst100_bcd", {12'd0, bcd}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    conv(16'd7, 20'h00007, 5, "din7");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end

endmodule
